// File: rtl/ftdi_bus_sched.sv
// FT245 synchronous FIFO bus scheduler: arbitrates RX reads and TX writes with burst quotas,
// round-robin fairness and a turnaround gap. Optional byte statistics via FTDI_BUS_SCHED_STATS_EN.
module ftdi_bus_sched #(
   parameter int RX_BURST_MAX = 64,
   parameter int TX_BURST_MAX = 64,
   parameter int TURN_CYC     = 2,
   parameter int CNT_W        = 8
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        rxf,
   input  logic        txe,
   input  logic        rx_space,
   input  logic        tx_avail,
   output logic        oe,
   output logic        rd,
   output logic        wr,
   output logic        rx_stb,
   output logic        tx_pop,
   output logic        dir_tx,
   output logic        busy,
   output logic [31:0] rx_bytes,
   output logic [31:0] tx_bytes,
   input  logic        stats_clr
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RX_OE    = 3'd1,
      RX_BURST = 3'd2,
      TX_BURST = 3'd3,
      TURN     = 3'd4
   } state_t;

   localparam logic DIR_RX = 1'b0;
   localparam logic DIR_TX = 1'b1;
   localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(RX_BURST_MAX - 1);
   localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(TX_BURST_MAX - 1);
   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             last_dir_r;
   logic             oe_r;
   logic             dir_tx_r;
   logic             busy_r;
   logic             rx_req_s;
   logic             tx_req_s;
   logic             rx_stb_s;
   logic             tx_pop_s;

   assign rx_req_s = ~rxf & rx_space;
   assign tx_req_s = ~txe & tx_avail;

   // Transfer strobes follow the live request so a dropped request stops the byte in the same cycle.
   always_comb begin
      rx_stb_s = 1'b0;
      tx_pop_s = 1'b0;
      case (state_r)
         RX_BURST: rx_stb_s = rx_req_s;
         TX_BURST: tx_pop_s = tx_req_s;
         default: begin
            rx_stb_s = 1'b0;
            tx_pop_s = 1'b0;
         end
      endcase
   end

   // Bus ownership FSM; oe/dir_tx/busy are registered alongside the state they belong to.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         last_dir_r <= DIR_TX;
         oe_r       <= 1'b1;
         dir_tx_r   <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               cnt_r <= '0;
               if (rx_req_s && (!tx_req_s || last_dir_r == DIR_TX)) begin
                  state_r <= RX_OE;
                  oe_r    <= 1'b0;
                  busy_r  <= 1'b1;
               end else if (tx_req_s) begin
                  state_r  <= TX_BURST;
                  dir_tx_r <= 1'b1;
                  busy_r   <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            RX_OE: begin
               state_r <= RX_BURST;
            end
            RX_BURST: begin
               if (!rx_req_s || cnt_r == RX_LAST) begin
                  state_r    <= TURN;
                  cnt_r      <= '0;
                  last_dir_r <= DIR_RX;
                  oe_r       <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            TX_BURST: begin
               if (!tx_req_s || cnt_r == TX_LAST) begin
                  state_r    <= TURN;
                  cnt_r      <= '0;
                  last_dir_r <= DIR_TX;
                  dir_tx_r   <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            TURN: begin
               if (cnt_r == TURN_LAST) begin
                  state_r <= IDLE;
                  cnt_r   <= '0;
                  busy_r  <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            default: begin
               state_r  <= IDLE;
               cnt_r    <= '0;
               oe_r     <= 1'b1;
               dir_tx_r <= 1'b0;
               busy_r   <= 1'b0;
            end
         endcase
      end
   end

   assign oe     = oe_r;
   assign dir_tx = dir_tx_r;
   assign busy   = busy_r;
   assign rd     = ~rx_stb_s;
   assign wr     = ~tx_pop_s;
   assign rx_stb = rx_stb_s;
   assign tx_pop = tx_pop_s;

`ifdef FTDI_BUS_SCHED_STATS_EN
   logic [31:0] rx_bytes_r;
   logic [31:0] tx_bytes_r;

   // Byte statistics; clear wins over a coincident increment.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rx_bytes_r <= 32'd0;
         tx_bytes_r <= 32'd0;
      end else if (stats_clr) begin
         rx_bytes_r <= 32'd0;
         tx_bytes_r <= 32'd0;
      end else begin
         if (rx_stb_s) begin
            rx_bytes_r <= rx_bytes_r + 32'd1;
         end else begin
            rx_bytes_r <= rx_bytes_r;
         end
         if (tx_pop_s) begin
            tx_bytes_r <= tx_bytes_r + 32'd1;
         end else begin
            tx_bytes_r <= tx_bytes_r;
         end
      end
   end

   assign rx_bytes = rx_bytes_r;
   assign tx_bytes = tx_bytes_r;
`else
   logic unused_stats_clr_s;

   assign unused_stats_clr_s = stats_clr;
   assign rx_bytes           = 32'd0;
   assign tx_bytes           = 32'd0;
`endif

endmodule

// File: doc/ftdi_bus_sched.md
Name: ftdi_bus_sched

Overview:
- Schedules the shared FT245 synchronous FIFO bus (one bidirectional data path) between host-to-FPGA reads (RX) and FPGA-to-host writes (TX).
- Drives the bus strobes directly: oe, rd, wr (all active-low). Enforces per-direction burst quotas, round-robin fairness and a bus turnaround gap.
- Sits between the FTDI pins and the RX/TX stream FIFOs of the SDRAM stream test path.

Parameters:
- RX_BURST_MAX, 64: max bytes read per RX grant (1..2^CNT_W).
- TX_BURST_MAX, 64: max bytes written per TX grant (1..2^CNT_W).
- TURN_CYC, 2: idle cycles after any burst before the next grant (>=1).
- CNT_W, 8: width of the burst and turnaround counters.

Ports:
- clk  in  1  FTDI 60 MHz clock; all logic on its rising edge.
- n_rst  in  1  asynchronous active-low reset.
- rxf  in  1  FTDI RX data available, active-low.
- txe  in  1  FTDI TX space available, active-low.
- rx_space  in  1  RX stream FIFO can accept a byte this cycle (1 = yes).
- tx_avail  in  1  TX stream FIFO holds a byte (1 = yes).
- oe  out  1  FTDI output enable, active-low.
- rd  out  1  FTDI read strobe, active-low.
- wr  out  1  FTDI write strobe, active-low.
- rx_stb  out  1  byte on bus is captured this edge into the RX FIFO.
- tx_pop  out  1  TX FIFO byte is consumed this edge.
- dir_tx  out  1  1 while the TX burst owns the bus (drives data tristate enable).
- busy  out  1  state != IDLE.
- rx_bytes  out  32  RX byte count (STATS_EN only).
- tx_bytes  out  32  TX byte count (STATS_EN only).
- stats_clr  in  1  synchronous clear of both stat counters (STATS_EN only).

Behaviour:
- States: IDLE, RX_OE, RX_BURST, TX_BURST, TURN. Registered state, burst counter cnt, last_dir.
- Reset (async): state=IDLE, cnt=0, last_dir=TX (RX wins first tie). oe=1, rd=1, wr=1, rx_stb=0, tx_pop=0, dir_tx=0, busy=0.
- Request terms: rx_req = !rxf && rx_space; tx_req = !txe && tx_avail.
- IDLE:
  - Only rx_req: go RX_OE.
  - Only tx_req: go TX_BURST.
  - Both: serve the direction opposite last_dir.
  - Neither: stay. cnt cleared on each grant.
- RX_OE: oe=0 registered for exactly one cycle, rd=1, no transfer. Then go RX_BURST (FT245 needs oe one clock ahead of rd).
- RX_BURST:
  - oe=0.
  - rd = !(rx_req) combinational; rx_stb = rx_req.
  - Each rx_stb: cnt+1.
  - Exit to TURN, with last_dir=RX, when:
    - rx_stb with cnt==RX_BURST_MAX-1, or
    - rx_req==0 in any cycle (rd already 1 that cycle).
- TX_BURST:
  - oe=1, dir_tx=1.
  - wr = !(tx_req); tx_pop = tx_req. Each tx_pop: cnt+1.
  - Exit to TURN, with last_dir=TX, on tx_pop with cnt==TX_BURST_MAX-1, or tx_req==0.
- TURN: oe=1, rd=1, wr=1, dir_tx=0. Hold TURN_CYC cycles (cnt reused, counts from 0), then go IDLE.
- Strobe exclusivity: rd==0 and wr==0 never both, ever. oe==0 never coincides with dir_tx==1.
- rx_stb/tx_pop are never asserted outside RX_BURST/TX_BURST.
- A quota of exactly one byte is legal: enter burst, one strobe, TURN.
- Simultaneous exit conditions: same result, TURN, no extra strobe.
- Reset mid-burst: strobes deassert immediately (async), no further stb/pop.
- Bytes per grant never exceed the quota. A continuously requesting direction yields the bus after its quota whenever the other requests.

Optional Feature:
- Macro: FTDI_BUS_SCHED_STATS_EN.
- Defined:
  - rx_bytes/tx_bytes are 32-bit counters, reset 0.
  - +1 on each rx_stb/tx_pop; wrap 0xFFFFFFFF -> 0.
  - stats_clr has priority over increment in the same cycle.
- Undefined: rx_bytes/tx_bytes driven constant 0, stats_clr ignored, no counter registers synthesised.

Test Plan:
- Reset, rxf=0, rx_space=1, txe=1 held: oe low 1 cycle, then rd low for 64 cycles (64 rx_stb), then TURN 2 cycles, then RX_OE again.
- rxf=0 and txe=0, rx_space=1, tx_avail=1 constant: bursts alternate RX(64)/TX(64). Every RX grant has exactly one RX_OE cycle before it. 2-cycle gap between bursts.
- TX burst, tx_avail drops after 10 pops: wr high same cycle, tx_pop total 10, TURN then IDLE. Pending RX served next.
- RX burst, rx_space low at byte 5: rd high that cycle, exactly 5 rx_stb. With rxf=0 and rx_space restored, a new grant follows after TURN.
- Assert n_rst=0 mid TX burst (byte 30): wr=1, oe=1, tx_pop=0 immediately. After release, state IDLE; RX wins the first tie.
- STATS_EN: 3 RX bursts of 64 and 1 TX of 10 -> rx_bytes=192, tx_bytes=10. stats_clr coincident with a tx_pop -> tx_bytes=0 next cycle.
